// File: rtl/bcd2binary_seq_if.sv
// Handshake and data bundle between the calculator control FSM (master)
// and the sequential BCD-to-binary converter (slave).
interface bcd2binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  binary,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output binary,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/bcd2binary_seq.sv
// Reverse double-dabble BCD-to-binary converter, one result bit per clock.
// Optional digit validity check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic             clk,
    input  logic             rst,
    bcd2binary_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int W_W   = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [W_W-1:0]   w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] binary_q, binary_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [W_W-1:0]   shifted_w;
    logic [W_W-1:0]   step_w;

    // One iteration: shift the whole work register right, then pull every
    // BCD digit that crossed 8 back down by 3 (undoes the doubling carry).
    assign shifted_w             = {1'b0, w_q[W_W-1:1]};
    assign step_w[BIN_W-1:0]     = shifted_w[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            logic [3:0] dig;
            assign dig = shifted_w[BIN_W + 4*gi +: 4];
            assign step_w[BIN_W + 4*gi +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
        end
    endgenerate

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic             err_q, err_d;
    logic [DIGITS-1:0] digit_bad;
    logic             any_bad;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign any_bad = |digit_bad;
`endif

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    if (any_bad) begin
                        // Reject immediately: no conversion, result forced to 0.
                        binary_d = '0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        w_d      = {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_CONV;
                    end
`else
                    w_d     = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
`endif
                end
            end
            ST_CONV: begin
                w_d   = step_w;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    binary_d = step_w[BIN_W-1:0];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            w_q      <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.binary = binary_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif
endmodule

// File: doc/bcd2binary_seq.md
Name: bcd2binary_seq

Overview:
- Sequential BCD-to-binary converter for the calculator datapath, running reverse double-dabble at one bit per clock.
- Converts DIGITS packed BCD digits, e.g. keypad-entered operands, into an unsigned binary value for the ALU.
- Uses a start/busy/done handshake so the control FSM can launch a conversion and wait for the result.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_W, 14, binary result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only while busy=0.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- binary  output  BIN_W  converted value; registered, held until next completion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; binary is valid in the same cycle.
- err  output  1  invalid-digit flag (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst); all state updates on the rising edge of clk.
- Reset values: binary=0, busy=0, done=0, err=0, FSM=IDLE, iteration counter=0, work register=0.
- Reset takes priority over all other inputs. Reset mid-conversion aborts it with no done pulse and binary=0.
- FSM states: IDLE, CONV.
- IDLE + start=1 at edge k:
  - Load work register W = {bcd_in, BIN_W zeros} (4*DIGITS+BIN_W bits).
  - cnt <= 0, busy <= 1, state <= CONV.
- IDLE + start=0: hold.
- CONV, each edge, one iteration:
  - Shift W right by 1; the bit leaving the BCD field enters the MSB of the binary field.
  - Then, for each 4-bit digit of the BCD field, if digit >= 8 subtract 3.
  - Both steps are combinational within the same cycle; cnt <= cnt+1.
- Final iteration (cnt = BIN_W-1), at edge k+BIN_W:
  - binary <= binary field of the updated W.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done high in the cycle after edge k+BIN_W, i.e. 14 cycles after the start edge with defaults.
- done is high for exactly one cycle; deasserts on the next edge unless a new completion occurs.
- start while busy=1 is ignored; the conversion continues and bcd_in changes have no effect.
- start is accepted in the same cycle done is high (busy=0 then). Back-to-back throughput is BIN_W+1 cycles per conversion.
- binary changes only on a completion edge or reset.
- No overflow is possible for valid input, given the BIN_W constraint.
- Arithmetic is unsigned only; no sign digit.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - On an accepted start, any digit of bcd_in > 9 skips CONV.
  - Next edge gives binary <= 0, err <= 1, done <= 1 (one-cycle pulse), busy stays 0.
  - err holds until the next accepted start or reset.
  - A valid accepted start clears err to 0 on its start edge.
- Undefined:
  - err is tied 0 and no digit check is done.
  - Invalid digits run through the normal algorithm; the result is unspecified but the timing is identical.

Test Plan:
- Reset, then start with bcd_in=16'h0255 → busy high 14 cycles, done pulse once, binary=255; err=0.
- bcd_in=16'h9999, then 16'h0000, then 16'h0001, back-to-back (start in the done cycle) → binary=9999, 0, 1; done spacing exactly 15 cycles.
- Start with 16'h1234, pulse start again and change bcd_in to 16'h0042 at cycle 5 of busy → single done, binary=1234; the second start is ignored.
- Start with 16'h0777, assert rst at cycle 6 of busy → next cycle busy=0, done=0, binary=0, no later done pulse; a following start with 16'h0010 → binary=10.
- With BCD2BIN_DIGIT_CHECK_EN, start with bcd_in=16'h00A0 → one cycle later done=1, err=1, binary=0. A next start with 16'h0099 → err clears on the start edge; binary=99 after 14 cycles.
- Exhaustive sweep: all valid inputs 0..9999 against a golden integer model → every binary matches and every latency = 14 cycles.
